change_dispenser: RTL

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser_if.sv | 36 +++
 rtl/change_dispenser.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/change_dispenser_if.sv
// change_dispenser_if
//   Groups the vending handshake and the dispenser outputs into one bundle.
//   master : the requester (vending front-end or testbench) that drives
//            vend_req/credit and observes the outputs.
//   slave  : the change_dispenser itself.
//   Signals:
//     vend_req   - one-cycle request to settle a purchase
//     credit     - inserted amount in 0.5-yuan units, sampled with vend_req
//     busy       - transaction in progress
//     drink_out  - drink-release pulse
//     coin1_out  - one 1-yuan coin per pulse
//     coin05_out - one 0.5-yuan coin per pulse
//     err        - one-cycle flag: credit was below the price
//     done       - one-cycle flag at transaction end
//     led        - remaining-change display
interface change_dispenser_if;
  logic       vend_req;
  logic [3:0] credit;
  logic       busy;
  logic       drink_out;
  logic       coin1_out;
  logic       coin05_out;
  logic       err;
  logic       done;
  logic [7:0] led;

  modport master (
    output vend_req, credit,
    input  busy, drink_out, coin1_out, coin05_out, err, done, led
  );

  modport slave (
    input  vend_req, credit,
    output busy, drink_out, coin1_out, coin05_out, err, done, led
  );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser
//   Settles a drink purchase: releases the drink when credit covers PRICE,
//   then pays the change greedily as 1-yuan coins followed by at most one
//   0.5-yuan coin. Insufficient credit is refunded the same way without a
//   drink. Every pulse lasts PULSE_CYC cycles and pulses are separated by
//   GAP_CYC low cycles.
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - synchronous active-low reset
//     bus   - change_dispenser_if.slave (vend_req, credit in; busy,
//             drink_out, coin1_out, coin05_out, err, done, led out)
//   Configuration:
//     CHANGE_LED_EN - when defined, led shows remaining change as a
//                     thermometer code; otherwise led is tied to zero.
module change_dispenser #(
  parameter int unsigned PRICE     = 5,
  parameter int unsigned PULSE_CYC = 25_000_000,
  parameter int unsigned GAP_CYC   = 25_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  change_dispenser_if.slave  bus
);

  localparam int unsigned MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRINK = 3'd1;
  localparam logic [2:0] S_PAY1  = 3'd2;
  localparam logic [2:0] S_PAY05 = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_remaining;
  logic          r_err;
  logic          w_credit_ok;

  assign w_credit_ok = (32'(bus.credit) >= PRICE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_remaining <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.vend_req) begin
            r_cnt <= '0;
            if (w_credit_ok) begin
              r_remaining <= bus.credit - 4'(PRICE);
              r_state     <= S_DRINK;
            end else begin
              // Refund path: whole credit is change, starting with a gap.
              r_remaining <= bus.credit;
              r_err       <= 1'b1;
              r_state     <= S_GAP;
            end
          end
        end
        S_DRINK: begin
          if (r_cnt == PULSE_LAST) begin
            r_cnt   <= '0;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_PAY1: begin
          if (r_cnt == PULSE_LAST) begin
            r_cnt       <= '0;
            r_remaining <= r_remaining - 4'd2;
            r_state     <= S_GAP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_PAY05: begin
          if (r_cnt == PULSE_LAST) begin
            r_cnt       <= '0;
            r_remaining <= r_remaining - 4'd1;
            r_state     <= S_GAP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt <= '0;
            // Greedy: 1-yuan coins while possible, the odd half last.
            if (r_remaining >= 4'd2) begin
              r_state <= S_PAY1;
            end else if (r_remaining == 4'd1) begin
              r_state <= S_PAY05;
            end else begin
              r_state <= S_FIN;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs decode from the state, so at most one pulse line is ever high.
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.drink_out  = (r_state == S_DRINK);
  assign bus.coin1_out  = (r_state == S_PAY1);
  assign bus.coin05_out = (r_state == S_PAY05);
  assign bus.done       = (r_state == S_FIN);
  assign bus.err        = r_err;

`ifdef CHANGE_LED_EN
  logic [7:0] w_led;

  // Bit i lit when remaining > i: thermometer, saturating at 8'hFF.
  always_comb begin
    w_led = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_led[i] = (32'(r_remaining) > i);
    end
  end

  assign bus.led = w_led;
`else
  assign bus.led = '0;
`endif

endmodule
